// File: rtl/tcp_vlg_ka_rsp_pkg.sv
// Shared types for the TCP keep-alive responder: connection control block,
// connection status, segment header view and responder FSM encoding.
package tcp_vlg_ka_rsp_pkg;

    localparam int KA_RSP_STAT_W = 16;

    typedef enum logic [1:0] {
        KA_RSP_IDLE = 2'd0,
        KA_RSP_REQ  = 2'd1,
        KA_RSP_GAP  = 2'd2
    } ka_rsp_fsm_t;

    typedef enum logic [2:0] {
        TCP_CLOSED    = 3'd0,
        TCP_LISTEN    = 3'd1,
        TCP_SYN_SENT  = 3'd2,
        TCP_SYN_RCVD  = 3'd3,
        TCP_CONNECTED = 3'd4,
        TCP_FIN_WAIT  = 3'd5,
        TCP_CLOSING   = 3'd6
    } tcp_stat_t;

    typedef struct packed {
        logic [15:0] loc_port;
        logic [15:0] rem_port;
        logic [31:0] loc_seq;
        logic [31:0] loc_ack;
    } tcb_t;

    typedef struct packed {
        logic urg;
        logic ack;
        logic psh;
        logic rst;
        logic syn;
        logic fin;
    } tcp_flags_t;

    typedef struct packed {
        logic [15:0] tcp_src_port;
        logic [15:0] tcp_dst_port;
        logic [31:0] tcp_seq_num;
        logic [31:0] tcp_ack_num;
        tcp_flags_t  tcp_flags;
    } tcp_hdr_t;

    // A keep-alive probe re-sends the byte just below our ack point (wraps at 0).
    function automatic logic is_ka_seq(input logic [31:0] seq, input logic [31:0] loc_ack);
        return (seq == (loc_ack - 32'd1));
    endfunction

endpackage

// File: rtl/tcp_vlg_ka_rsp_if.sv
// Receive-metadata and ACK-request handshake bundle between the keep-alive
// responder (slave side) and the rx path / tx engine (master side).
interface tcp_vlg_ka_rsp_if;
    import tcp_vlg_ka_rsp_pkg::*;

    logic        rx_val;
    tcp_hdr_t    rx_hdr;
    logic [15:0] rx_pld_len;
    logic        send;
    logic [31:0] send_seq;
    logic [31:0] send_ack;
    logic        sent;
    logic        drop;

    modport master (
        output rx_val, rx_hdr, rx_pld_len, sent,
        input  send, send_seq, send_ack, drop
    );

    modport slave (
        input  rx_val, rx_hdr, rx_pld_len, sent,
        output send, send_seq, send_ack, drop
    );

endinterface

// File: rtl/tcp_vlg_ka_rsp.sv
// Keep-alive responder: detects remote keep-alive probes and requests one rate-limited
// pure ACK per burst. Optional probe counter built with `define TCP_VLG_KA_RSP_STAT_EN.
module tcp_vlg_ka_rsp
    import tcp_vlg_ka_rsp_pkg::*;
#(
    parameter int MIN_GAP    = 125000000,
    parameter int TX_TIMEOUT = 1250000,
    parameter int VERBOSE    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  tcb_t                     i_tcb,
    input  tcp_stat_t                i_status,
    tcp_vlg_ka_rsp_if.slave          io_ka,
    output logic [KA_RSP_STAT_W-1:0] o_probes
);

    localparam int GAP_N = (MIN_GAP < 1) ? 1 : MIN_GAP;
    localparam int TMO_N = (TX_TIMEOUT < 1) ? 1 : TX_TIMEOUT;
    localparam int GAP_W = $clog2(GAP_N + 1);
    localparam int TMO_W = $clog2(TMO_N + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_N - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_N - 1);

    logic              r_int_rst;
    ka_rsp_fsm_t       r_state;
    ka_rsp_fsm_t       w_state_nx;
    logic              r_pend;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_nx;
    logic [TMO_W-1:0]  r_tmo;
    logic [TMO_W-1:0]  w_tmo_nx;
    logic              r_send;
    logic              r_drop;
    logic              w_drop_nx;
    logic              w_issue;
    logic              w_probe;
    logic [31:0]       r_send_seq;
    logic [31:0]       r_send_ack;
    logic              w_unused;

    // Header fields this block does not look at; VERBOSE has no effect in hardware.
    assign w_unused = ^{io_ka.rx_hdr.tcp_ack_num, io_ka.rx_hdr.tcp_flags.urg,
                        io_ka.rx_hdr.tcp_flags.psh, (VERBOSE != 0)};

    // Probe detection on the incoming segment metadata
    always_comb begin
        w_probe = 1'b0;
        if (io_ka.rx_val &&
            (io_ka.rx_hdr.tcp_dst_port == i_tcb.loc_port) &&
            (io_ka.rx_hdr.tcp_src_port == i_tcb.rem_port) &&
            io_ka.rx_hdr.tcp_flags.ack && !io_ka.rx_hdr.tcp_flags.syn &&
            !io_ka.rx_hdr.tcp_flags.fin && !io_ka.rx_hdr.tcp_flags.rst &&
            is_ka_seq(io_ka.rx_hdr.tcp_seq_num, i_tcb.loc_ack) &&
            (io_ka.rx_pld_len <= 16'd1)) begin
            w_probe = 1'b1;
        end else begin
            w_probe = 1'b0;
        end
    end

    // Internal reset: local reset or loss of the connection, applied one cycle later
    always_ff @(posedge clk) begin
        r_int_rst <= rst || (i_status != TCP_CONNECTED);
    end

    // Next-state, counter and pulse decode
    always_comb begin
        w_state_nx = r_state;
        w_gap_nx   = r_gap;
        w_tmo_nx   = r_tmo;
        w_drop_nx  = 1'b0;
        w_issue    = 1'b0;
        case (r_state)
            KA_RSP_IDLE: begin
                w_gap_nx = {GAP_W{1'b0}};
                w_tmo_nx = {TMO_W{1'b0}};
                if (r_pend) begin
                    w_state_nx = KA_RSP_REQ;
                    w_issue    = 1'b1;
                end else begin
                    w_state_nx = KA_RSP_IDLE;
                end
            end
            KA_RSP_REQ: begin
                // sent has priority over a timeout on the same cycle
                if (io_ka.sent) begin
                    w_state_nx = KA_RSP_GAP;
                    w_gap_nx   = {GAP_W{1'b0}};
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nx = KA_RSP_GAP;
                    w_gap_nx   = {GAP_W{1'b0}};
                    w_drop_nx  = 1'b1;
                end else begin
                    w_tmo_nx = r_tmo + TMO_W'(1);
                end
            end
            KA_RSP_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nx = KA_RSP_IDLE;
                end else begin
                    w_gap_nx = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nx = KA_RSP_IDLE;
                w_gap_nx   = {GAP_W{1'b0}};
                w_tmo_nx   = {TMO_W{1'b0}};
            end
        endcase
    end

    // State register, pending flag, counters and registered request outputs
    always_ff @(posedge clk) begin
        if (rst || r_int_rst) begin
            r_state    <= KA_RSP_IDLE;
            r_pend     <= 1'b0;
            r_gap      <= {GAP_W{1'b0}};
            r_tmo      <= {TMO_W{1'b0}};
            r_send     <= 1'b0;
            r_drop     <= 1'b0;
            r_send_seq <= 32'd0;
            r_send_ack <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_gap   <= w_gap_nx;
            r_tmo   <= w_tmo_nx;
            r_send  <= (w_state_nx == KA_RSP_REQ);
            r_drop  <= w_drop_nx;
            // Probes coalesce; one arriving on the issue cycle re-arms pend
            r_pend  <= w_probe || (r_pend && !w_issue);
            if (w_issue) begin
                r_send_seq <= i_tcb.loc_seq;
                r_send_ack <= i_tcb.loc_ack;
            end
        end
    end

    assign io_ka.send     = r_send;
    assign io_ka.drop     = r_drop;
    assign io_ka.send_seq = r_send_seq;
    assign io_ka.send_ack = r_send_ack;

`ifdef TCP_VLG_KA_RSP_STAT_EN
    logic [KA_RSP_STAT_W-1:0] r_probes;

    // Saturating count of probe cycles
    always_ff @(posedge clk) begin
        if (rst || r_int_rst) begin
            r_probes <= {KA_RSP_STAT_W{1'b0}};
        end else if (w_probe && (r_probes != {KA_RSP_STAT_W{1'b1}})) begin
            r_probes <= r_probes + KA_RSP_STAT_W'(1);
        end
    end

    assign o_probes = r_probes;
`else
    assign o_probes = {KA_RSP_STAT_W{1'b0}};
`endif

endmodule
